// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serializer_pkg
//  Description : Shared types and defaults for the serializer datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int DEF_DATA_W = 32;

endpackage : serializer_pkg
`default_nettype wire

// File: rtl/piso_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shifter
//  Description : Parallel-in/serial-out framing stage, valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shifter
    import serializer_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = $clog2(DATA_W),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CNT_W-1:0]  in_len,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_first,
    output logic              frame_done,
    output logic              busy
);

    localparam logic [CNT_W-1:0] MAX_IDX = CNT_W'(DATA_W - 1);

    piso_state_t       state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  len_q;

    logic [CNT_W-1:0]  len_in;
    logic [CNT_W-1:0]  pad;
    logic [DATA_W-1:0] masked;
    logic [DATA_W-1:0] load_word;
    logic              accept;
    logic              transfer;
    logic              last_bit;

    // Unused high bits are masked off at load so the register drains to zero
    // and ser_out idles low once the frame has been shifted out.
    assign len_in    = (in_len > MAX_IDX) ? MAX_IDX : in_len;
    assign pad       = MAX_IDX - len_in;
    assign masked    = in_data & ({DATA_W{1'b1}} >> pad);
    assign load_word = MSB_FIRST ? (masked << pad) : masked;

    always_comb begin
        in_ready   = 1'b0;
        ser_valid  = 1'b0;
        ser_first  = 1'b0;
        frame_done = 1'b0;
        busy       = 1'b0;
        last_bit   = (bit_cnt == len_q);
        ser_out    = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                ser_valid  = 1'b1;
                busy       = 1'b1;
                ser_first  = (bit_cnt == '0);
                frame_done = last_bit;
                in_ready   = last_bit & ser_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
        accept   = in_valid & in_ready;
        transfer = ser_valid & ser_ready;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            len_q   <= '0;
        end else if (accept) begin
            // Also covers the last-bit reload that gives zero-bubble frames.
            state   <= SHIFT;
            shreg   <= load_word;
            bit_cnt <= '0;
            len_q   <= len_in;
        end else if (transfer) begin
            shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            if (last_bit) begin
                state   <= IDLE;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule : piso_shifter
`default_nettype wire

// File: tb/tb_piso_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_shifter
//  Description : Self-checking bench driving LSB-first and MSB-first instances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shifter;

    logic        clk;
    logic        resetN;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_len;
    logic        ser_ready;

    logic l_in_ready, l_out, l_valid, l_first, l_done, l_busy;
    logic m_in_ready, m_out, m_valid, m_first, m_done, m_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic bl;
        logic bm;
        logic first;
        logic last;
    } exp_t;

    exp_t q[$];
    bit   acc;
    bit   rnd_ready = 0;

    piso_shifter #(.DATA_W(32), .CNT_W(5), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .resetN(resetN), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_data(in_data), .in_len(in_len), .ser_out(l_out), .ser_valid(l_valid),
        .ser_ready(ser_ready), .ser_first(l_first), .frame_done(l_done), .busy(l_busy)
    );

    piso_shifter #(.DATA_W(32), .CNT_W(5), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .resetN(resetN), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_data(in_data), .in_len(in_len), .ser_out(m_out), .ser_valid(m_valid),
        .ser_ready(ser_ready), .ser_first(m_first), .frame_done(m_done), .busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame as a list of bits: bit i of the LSB-first stream is data[i],
    // bit i of the MSB-first stream is data[len-i].
    task automatic push_frame(input logic [31:0] d, input int len);
        exp_t e;
        for (int i = 0; i <= len; i++) begin
            e.bl    = d[i];
            e.bm    = d[len - i];
            e.first = (i == 0);
            e.last  = (i == len);
            q.push_back(e);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_l_out"},   {31'd0, l_out},   32'd0);
        chk({tag, "_l_valid"}, {31'd0, l_valid}, 32'd0);
        chk({tag, "_l_flags"}, {30'd0, l_first, l_done}, 32'd0);
        chk({tag, "_l_busy"},  {31'd0, l_busy},  32'd0);
        chk({tag, "_m_out"},   {31'd0, m_out},   32'd0);
        chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
        chk({tag, "_m_flags"}, {30'd0, m_first, m_done}, 32'd0);
        chk({tag, "_m_busy"},  {31'd0, m_busy},  32'd0);
    endtask

    // One clock: check at negedge against the model, advance the model, then
    // return 1 ns after the rising edge so the caller can drive new inputs.
    task automatic step();
        logic exp_v, exp_rdy;
        if (rnd_ready) ser_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        exp_v   = (q.size() != 0);
        exp_rdy = (q.size() == 0) || (q.size() == 1 && ser_ready);
        chk("l_valid", {31'd0, l_valid}, {31'd0, exp_v});
        chk("m_valid", {31'd0, m_valid}, {31'd0, exp_v});
        chk("l_busy",  {31'd0, l_busy},  {31'd0, exp_v});
        chk("m_busy",  {31'd0, m_busy},  {31'd0, exp_v});
        chk("l_in_ready", {31'd0, l_in_ready}, {31'd0, exp_rdy});
        chk("m_in_ready", {31'd0, m_in_ready}, {31'd0, exp_rdy});
        if (exp_v) begin
            chk("l_bit",   {31'd0, l_out},   {31'd0, q[0].bl});
            chk("m_bit",   {31'd0, m_out},   {31'd0, q[0].bm});
            chk("l_first", {31'd0, l_first}, {31'd0, q[0].first});
            chk("m_first", {31'd0, m_first}, {31'd0, q[0].first});
            chk("l_done",  {31'd0, l_done},  {31'd0, q[0].last});
            chk("m_done",  {31'd0, m_done},  {31'd0, q[0].last});
        end
        acc = 1'b0;
        if (ser_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid && exp_rdy) begin
            push_frame(in_data, int'(in_len));
            acc = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] len, input bit keep);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_len   = len;
        do begin
            step();
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("accept_timeout", 32'd1, 32'd0);
        if (!keep) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            in_len   = 5'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        step();
    endtask

    initial begin
        resetN    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        ser_ready = 1'b1;
        #2;
        check_idle_outputs("reset");
        chk("reset_l_in_ready", {31'd0, l_in_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        step();

        // LSB-first byte, then zero-bubble back-to-back nibbles.
        send(32'hA5, 5'd7, 0);
        drain();
        send(32'h9, 5'd3, 1);
        send(32'h6, 5'd3, 0);
        drain();

        // Downstream stall of three cycles after the second bit.
        send(32'hA5, 5'd7, 0);
        step();
        step();
        ser_ready = 1'b0;
        repeat (3) step();
        ser_ready = 1'b1;
        drain();

        // Asynchronous reset mid-frame, then a clean frame afterwards.
        send(32'h1234_5678, 5'd15, 0);
        repeat (4) step();
        resetN = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        step();
        send(32'h3C, 5'd7, 0);
        drain();

        // Single-bit frame and the full-width / MSB-first cases.
        send(32'hFFFF_FFFE, 5'd0, 0);
        drain();
        send(32'h0000_000B, 5'd3, 0);
        drain();
        send(32'h8000_0001, 5'd31, 0);
        drain();

        // Randomized frames, gaps and downstream backpressure.
        rnd_ready = 1;
        for (int f = 0; f < 30; f++) begin
            bit keep;
            keep = ($urandom_range(0, 1) == 1);
            send($urandom, 5'($urandom_range(0, 31)), keep);
            if (!keep) repeat ($urandom_range(0, 3)) step();
        end
        in_valid = 1'b0;
        rnd_ready = 0;
        ser_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_piso_shifter
`default_nettype wire
